// File: rtl/ahb_slave_mux.sv
// ahb_slave_mux: AHB-Lite address decoder, data-phase response mux and ERROR default slave.
// Define AHB_MUX_TIMEOUT_EN to abort stalled slaves after TIMEOUT_CYCLES wait states.
module ahb_slave_mux #(
   parameter logic [3:0] S0_REGION      = 4'h8,
   parameter logic [3:0] S1_REGION      = 4'h9,
   parameter logic [3:0] S2_REGION      = 4'hA,
   parameter logic [3:0] S3_REGION      = 4'hB,
   parameter int         TIMEOUT_CYCLES = 256
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   output logic        hready,
   output logic [31:0] hrdata,
   output logic [1:0]  hresp,
   output logic [3:0]  hsel_s,
   input  logic [31:0] hrdata_s0,
   input  logic [31:0] hrdata_s1,
   input  logic [31:0] hrdata_s2,
   input  logic [31:0] hrdata_s3,
   input  logic        hready_s0,
   input  logic        hready_s1,
   input  logic        hready_s2,
   input  logic        hready_s3,
   input  logic [1:0]  hresp_s0,
   input  logic [1:0]  hresp_s1,
   input  logic [1:0]  hresp_s2,
   input  logic [1:0]  hresp_s3,
   output logic        timeout_flag
);
   typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
   state_t      r_state, w_next;
   logic [2:0]  r_dsel, w_idx;
   logic [31:0] w_rd [4];
   logic [1:0]  w_rsp [4];
   logic [3:0]  w_rdy;
   logic        w_def, w_err_req, w_stall, w_tmo, w_unused;
   assign w_rd  = '{hrdata_s0, hrdata_s1, hrdata_s2, hrdata_s3};
   assign w_rsp = '{hresp_s0, hresp_s1, hresp_s2, hresp_s3};
   assign w_rdy = {hready_s3, hready_s2, hready_s1, hready_s0};
   assign w_unused = ^{hwrite, haddr[27:0]};
   always_comb begin
      w_idx = haddr[31:28] == S0_REGION ? 3'd0 :
              haddr[31:28] == S1_REGION ? 3'd1 :
              haddr[31:28] == S2_REGION ? 3'd2 :
              haddr[31:28] == S3_REGION ? 3'd3 : 3'd4;
      hsel_s = w_idx[2] ? 4'b0000 : 4'b0001 << w_idx[1:0];
   end
   // Any non-IDLE FSM state owns the response, including a timeout abort of a mapped slave.
   always_comb begin
      w_def  = (r_state != IDLE) || r_dsel[2];
      hready = w_def ? (r_state != ERR1) : w_rdy[r_dsel[1:0]];
      hresp  = w_def ? ((r_state == IDLE) ? 2'b00 : 2'b01) : w_rsp[r_dsel[1:0]];
      hrdata = w_def ? 32'h0 : w_rd[r_dsel[1:0]];
   end
   assign w_err_req = hready && w_idx[2] && htrans[1];
   assign w_stall   = (r_state == IDLE) && !r_dsel[2] && !w_rdy[r_dsel[1:0]];
`ifdef AHB_MUX_TIMEOUT_EN
   logic [15:0] r_wcnt;
   logic        r_tflag;
   // Entering ERR1 on the edge where the count reaches TIMEOUT_CYCLES-1.
   assign w_tmo = w_stall && (r_wcnt == 16'(TIMEOUT_CYCLES - 2));
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_wcnt  <= '0;
         r_tflag <= 1'b0;
      end else begin
         r_wcnt  <= hready ? 16'h0 : (w_stall ? r_wcnt + 16'h1 : r_wcnt);
         r_tflag <= r_tflag | w_tmo;
      end
   end
   assign timeout_flag = r_tflag;
`else
   assign w_tmo        = 1'b0;
   assign timeout_flag = 1'b0;
`endif
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state <= IDLE;
         r_dsel  <= 3'd4;
      end else begin
         r_state <= w_next;
         r_dsel  <= hready ? w_idx : r_dsel;
      end
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = (w_err_req || w_tmo) ? ERR1 : IDLE;
         ERR1:    w_next = ERR2;
         ERR2:    w_next = w_err_req ? ERR1 : IDLE;
         default: w_next = IDLE;
      endcase
   end
endmodule
